tone_decoder: RTL and testbench

Receive-side counterpart of the keyboard tone generator. Measures the half-period of a 1-bit square-wave audio input, classifies it against the eight note divisors (DO..DO2), and outputs the 3-bit key code once the pitch is stable. Used for loopback self-test of the synthesizer output and for pitch-to-code capture from an external square-wave source.

---
 rtl/tone_pkg.sv | 49 ++++
 rtl/tone_classifier.sv | 31 +++
 rtl/tone_decoder.sv | 151 +++++++++++++++
 tb/tb_tone_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg
//   Constants shared by the tone generator and the tone decoder:
//   - the eight note divisors L (the generator toggles its output every L+1 clocks)
//   - the 3-bit note code enumeration {key3,key2,key1}
//   - the decoder FSM state encoding
//   - nominal_half(): maps a note code to its nominal half-period (L+1)
package tone_pkg;

  localparam logic [31:0] DIV_DO  = 32'd191112;
  localparam logic [31:0] DIV_RE  = 32'd170267;
  localparam logic [31:0] DIV_MI  = 32'd151682;
  localparam logic [31:0] DIV_FA  = 32'd143172;
  localparam logic [31:0] DIV_SOL = 32'd127552;
  localparam logic [31:0] DIV_LA  = 32'd113636;
  localparam logic [31:0] DIV_SI  = 32'd101238;
  localparam logic [31:0] DIV_DO2 = 32'd95451;

  typedef enum logic [2:0] {
    NOTE_DO  = 3'd0,
    NOTE_RE  = 3'd1,
    NOTE_MI  = 3'd2,
    NOTE_FA  = 3'd3,
    NOTE_SOL = 3'd4,
    NOTE_LA  = 3'd5,
    NOTE_SI  = 3'd6,
    NOTE_DO2 = 3'd7
  } note_code_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // The generator counts 0..L before toggling, so one half-period is L+1 clocks.
  function automatic logic [31:0] nominal_half(input logic [2:0] code);
    logic [31:0] div;
    case (note_code_e'(code))
      NOTE_DO:  div = DIV_DO;
      NOTE_RE:  div = DIV_RE;
      NOTE_MI:  div = DIV_MI;
      NOTE_FA:  div = DIV_FA;
      NOTE_SOL: div = DIV_SOL;
      NOTE_LA:  div = DIV_LA;
      NOTE_SI:  div = DIV_SI;
      default:  div = DIV_DO2;
    endcase
    return div + 32'd1;
  endfunction

endpackage

// File: rtl/tone_classifier.sv
// tone_classifier
//   Combinational pitch classifier.
//   Ports:
//     h     in  [31:0] measured half-period in clk cycles
//     hit   out        h lies within +/-TOL of one nominal half-period
//     code  out [2:0]  note code of the matching nominal (0 when no hit)
//   The nominals are far more than 2*TOL apart, so at most one entry matches.
module tone_classifier #(
  parameter int unsigned TOL = 64
) (
  input  logic [31:0] h,
  output logic        hit,
  output logic [2:0]  code
);
  import tone_pkg::*;

  localparam logic [31:0] TOL_W = 32'(TOL);

  // Window written as two unsigned bounds so no signed subtraction is needed.
  always_comb begin
    hit  = 1'b0;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((h >= nominal_half(3'(i)) - TOL_W) && (h <= nominal_half(3'(i)) + TOL_W)) begin
        hit  = 1'b1;
        code = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder
//   Measures the half-period of a square-wave audio input, classifies it
//   against the eight note divisors and reports the key code once the pitch
//   has been stable for LOCK_COUNT consecutive half-periods.
//   Ports:
//     clk          in         system clock
//     reset        in         asynchronous, active-high reset
//     audio_in     in         square-wave audio, asynchronous to clk
//     note_code    out [2:0]  decoded key code (000 DO .. 111 DO2)
//     note_valid   out        high while a locked note is present
//     note_change  out        one-cycle pulse on lock or on a code change while valid
//     half_period  out [31:0] last measured half-period in clk cycles
module tone_decoder #(
  parameter int unsigned TOL        = 64,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 262143
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_in,
  output logic [2:0]  note_code,
  output logic        note_valid,
  output logic        note_change,
  output logic [31:0] half_period
);
  import tone_pkg::*;

  localparam logic [31:0]       TIMEOUT_W = 32'(TIMEOUT);
  localparam int                CNT_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  LOCK_W    = CNT_W'(LOCK_COUNT);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [31:0]      edge_cnt_q, edge_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cand_cnt_q, cand_cnt_d;
  logic [2:0]       note_code_q, note_code_d;
  logic             note_valid_q, note_valid_d;
  logic             note_change_q, note_change_d;
  logic [31:0]      half_period_q, half_period_d;

  logic             edge_det;
  logic             timeout;
  logic             hit;
  logic [2:0]       hit_code;

  // The counter value at an edge is exactly the number of cycles since the
  // previous edge, so it is classified directly.
  tone_classifier #(.TOL(TOL)) u_classifier (
    .h    (edge_cnt_q),
    .hit  (hit),
    .code (hit_code)
  );

  always_comb begin
    sync1_d       = audio_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    edge_cnt_d    = edge_cnt_q;
    state_d       = state_q;
    cand_d        = cand_q;
    cand_cnt_d    = cand_cnt_q;
    note_code_d   = note_code_q;
    note_valid_d  = note_valid_q;
    note_change_d = 1'b0;
    half_period_d = half_period_q;

    edge_det = sync2_q ^ prev_q;
    timeout  = (edge_cnt_q == TIMEOUT_W);

    if (edge_det) begin
      edge_cnt_d = 32'd1;
    end else if (!timeout) begin
      edge_cnt_d = edge_cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // First edge only starts the measurement; there is no interval yet.
        if (edge_det) state_d = ST_MEASURE;
      end
      ST_MEASURE, ST_LOCKED: begin
        // An edge takes priority over a coincident timeout.
        if (edge_det) begin
          half_period_d = edge_cnt_q;
          if (!hit) begin
            cand_cnt_d   = '0;
            note_valid_d = 1'b0;
            state_d      = ST_MEASURE;
          end else begin
            if (hit_code == cand_q) begin
              if (cand_cnt_q != LOCK_W) cand_cnt_d = cand_cnt_q + CNT_W'(1);
            end else begin
              cand_d     = hit_code;
              cand_cnt_d = CNT_W'(1);
            end
            // While locked, the old code keeps being reported until the new
            // candidate has accumulated a full lock count.
            if ((cand_cnt_d == LOCK_W) && (!note_valid_q || (cand_d != note_code_q))) begin
              note_code_d   = cand_d;
              note_valid_d  = 1'b1;
              note_change_d = 1'b1;
              state_d       = ST_LOCKED;
            end
          end
        end else if (timeout) begin
          note_valid_d = 1'b0;
          cand_cnt_d   = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      edge_cnt_q    <= '0;
      state_q       <= ST_IDLE;
      cand_q        <= '0;
      cand_cnt_q    <= '0;
      note_code_q   <= '0;
      note_valid_q  <= 1'b0;
      note_change_q <= 1'b0;
      half_period_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      edge_cnt_q    <= edge_cnt_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cand_cnt_q    <= cand_cnt_d;
      note_code_q   <= note_code_d;
      note_valid_q  <= note_valid_d;
      note_change_q <= note_change_d;
      half_period_q <= half_period_d;
    end
  end

  assign note_code   = note_code_q;
  assign note_valid  = note_valid_q;
  assign note_change = note_change_q;
  assign half_period = half_period_q;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder
//   Table of half-periods with expected outputs, hand-written sequences for
//   glitch / silence / async reset, and a randomized burst stream checked
//   against a history-based reference model.
module tb_tone_decoder;

  localparam int TOL     = 64;
  localparam int LOCK    = 4;
  localparam int TIMEOUT = 262143;

  // Nominal half-periods DO..DO2 in clk cycles.
  localparam int NOM [8] = '{191113, 170268, 151683, 143173, 127553, 113637, 101239, 95452};

  logic        clk;
  logic        reset;
  logic        audio_in;
  logic [2:0]  note_code;
  logic        note_valid;
  logic        note_change;
  logic [31:0] half_period;

  tone_decoder #(.TOL(TOL), .LOCK_COUNT(LOCK), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_in    (audio_in),
    .note_code   (note_code),
    .note_valid  (note_valid),
    .note_change (note_change),
    .half_period (half_period)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int          checks;
  int          errors;
  int          since;
  bit          last_v;
  logic [2:0]  last_c;
  logic [31:0] last_hp;

  // reference model state: codes of consecutive hits since the last miss
  int          hist[$];
  bit          m_v;
  logic [2:0]  m_c;

  typedef struct {
    int          h;
    bit          v;
    logic [2:0]  c;
    bit          chg;
    logic [31:0] hp;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit ev, input logic [2:0] ec,
                         input bit echg, input logic [31:0] ehp);
    chk({nm, ".valid"},  32'(note_valid),  32'(ev));
    chk({nm, ".code"},   32'(note_code),   32'(ec));
    chk({nm, ".change"}, 32'(note_change), 32'(echg));
    chk({nm, ".hp"},     half_period,      ehp);
  endtask

  // Toggle audio_in h clocks after the previous toggle, check that nothing
  // has moved 2 clocks later, the new values 3 clocks later, and that the
  // change pulse is gone on the following clock.
  task automatic edge_after(input int h, input string nm, input bit ev,
                            input logic [2:0] ec, input bit echg, input logic [31:0] ehp);
    if (h > since) repeat (h - since) @(negedge clk);
    audio_in = ~audio_in;
    repeat (2) @(negedge clk);
    chk_all({nm, ".pre"}, last_v, last_c, 1'b0, last_hp);
    @(negedge clk);
    chk_all(nm, ev, ec, echg, ehp);
    @(negedge clk);
    chk({nm, ".chg_off"}, 32'(note_change), 32'd0);
    since   = 4;
    last_v  = ev;
    last_c  = ec;
    last_hp = ehp;
  endtask

  function automatic int classify(input int h);
    int d;
    for (int k = 0; k < 8; k++) begin
      d = (h > NOM[k]) ? h - NOM[k] : NOM[k] - h;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  // Valid once the trailing run of identical hits reaches LOCK; the reported
  // code is that of the most recent run to do so.
  task automatic model_sample(input int h, output bit ev, output logic [2:0] ec, output bit echg);
    int k;
    int r;
    k    = classify(h);
    echg = 1'b0;
    if (k < 0) begin
      hist.delete();
      m_v = 1'b0;
    end else begin
      hist.push_back(k);
      r = 0;
      for (int j = hist.size() - 1; j >= 0; j--) begin
        if (hist[j] != k) break;
        r++;
      end
      if (r >= LOCK && (!m_v || m_c != 3'(k))) begin
        m_v  = 1'b1;
        m_c  = 3'(k);
        echg = 1'b1;
      end
    end
    ev = m_v;
    ec = m_c;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset    = 1'b1;
    audio_in = 1'b0;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    since   = 0;
    last_v  = 1'b0;
    last_c  = 3'd0;
    last_hp = 32'd0;
    hist.delete();
    m_v = 1'b0;
    m_c = 3'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          ev;
    logic [2:0]  ec;
    bit          echg;
    int          code;
    int          len;
    int          h;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    audio_in = 1'b0;

    // locks LA, moves to DO2, then exercises the DO tolerance window
    tbl[0]  = '{8,      1'b0, 3'd0, 1'b0, 32'd0};
    tbl[1]  = '{113637, 1'b0, 3'd0, 1'b0, 32'd113637};
    tbl[2]  = '{113637, 1'b0, 3'd0, 1'b0, 32'd113637};
    tbl[3]  = '{113637, 1'b0, 3'd0, 1'b0, 32'd113637};
    tbl[4]  = '{113637, 1'b1, 3'd5, 1'b1, 32'd113637};
    tbl[5]  = '{113637, 1'b1, 3'd5, 1'b0, 32'd113637};
    tbl[6]  = '{95452,  1'b1, 3'd5, 1'b0, 32'd95452};
    tbl[7]  = '{95452,  1'b1, 3'd5, 1'b0, 32'd95452};
    tbl[8]  = '{95452,  1'b1, 3'd5, 1'b0, 32'd95452};
    tbl[9]  = '{95452,  1'b1, 3'd7, 1'b1, 32'd95452};
    tbl[10] = '{191177, 1'b1, 3'd7, 1'b0, 32'd191177};
    tbl[11] = '{191177, 1'b1, 3'd7, 1'b0, 32'd191177};
    tbl[12] = '{191177, 1'b1, 3'd7, 1'b0, 32'd191177};
    tbl[13] = '{191177, 1'b1, 3'd0, 1'b1, 32'd191177};
    tbl[14] = '{191178, 1'b0, 3'd0, 1'b0, 32'd191178};
    tbl[15] = '{191049, 1'b0, 3'd0, 1'b0, 32'd191049};
    tbl[16] = '{191048, 1'b0, 3'd0, 1'b0, 32'd191048};

    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, 3'd0, 1'b0, 32'd0);
    reset   = 1'b0;
    since   = 0;
    last_v  = 1'b0;
    last_c  = 3'd0;
    last_hp = 32'd0;

    for (int i = 0; i < 17; i++)
      edge_after(tbl[i].h, $sformatf("vec%0d", i), tbl[i].v, tbl[i].c, tbl[i].chg, tbl[i].hp);

    // glitch inside a locked DO2 stream, then relock
    for (int i = 0; i < 3; i++) edge_after(95452, $sformatf("g_lock%0d", i), 1'b0, 3'd0, 1'b0, 32'd95452);
    edge_after(95452, "g_locked", 1'b1, 3'd7, 1'b1, 32'd95452);
    edge_after(95452, "g_hold",   1'b1, 3'd7, 1'b0, 32'd95452);
    edge_after(1000,  "g_glitch", 1'b0, 3'd7, 1'b0, 32'd1000);
    for (int i = 0; i < 3; i++) edge_after(95452, $sformatf("g_re%0d", i), 1'b0, 3'd7, 1'b0, 32'd95452);
    edge_after(95452, "g_relock", 1'b1, 3'd7, 1'b1, 32'd95452);

    // silence: valid drops TIMEOUT cycles after the last registered edge
    repeat (TIMEOUT + 2 - since) @(negedge clk);
    chk("timeout.before", 32'(note_valid), 32'd1);
    @(negedge clk);
    chk_all("timeout", 1'b0, 3'd7, 1'b0, 32'd95452);
    since  = TIMEOUT + 3;
    last_v = 1'b0;
    // first edge after silence only re-arms; no sample is taken
    edge_after(TIMEOUT + 20, "idle_edge", 1'b0, 3'd7, 1'b0, 32'd95452);

    // lock again, then an async reset between clock edges
    for (int i = 0; i < 3; i++) edge_after(95452, $sformatf("r_lock%0d", i), 1'b0, 3'd7, 1'b0, 32'd95452);
    edge_after(95452, "r_locked", 1'b1, 3'd7, 1'b1, 32'd95452);
    repeat (1000) @(negedge clk);
    #3 reset = 1'b1;
    #1 chk_all("reset_async", 1'b0, 3'd0, 1'b0, 32'd0);
    audio_in = 1'b0;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    since   = 0;
    last_v  = 1'b0;
    last_c  = 3'd0;
    last_hp = 32'd0;
    edge_after(8, "rl_arm", 1'b0, 3'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) edge_after(95452, $sformatf("rl%0d", i), 1'b0, 3'd0, 1'b0, 32'd95452);
    edge_after(95452, "rl_locked", 1'b1, 3'd7, 1'b1, 32'd95452);

    // randomized bursts around LA/SI/DO2, with boundary offsets and short misses
    sync_reset();
    edge_after(8, "rnd_arm", 1'b0, 3'd0, 1'b0, 32'd0);
    for (int b = 0; b < 6; b++) begin
      code = int'($urandom_range(5, 7));
      len  = int'($urandom_range(2, 6));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 9) == 0) h = int'($urandom_range(200, 3000));
        else h = NOM[code] + int'($urandom_range(0, 2 * TOL + 16)) - (TOL + 8);
        model_sample(h, ev, ec, echg);
        edge_after(h, $sformatf("rnd%0d_%0d", b, j), ev, ec, echg, 32'(h));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
